// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver with hex decode, decimal points, per-digit
// blank/blink, a fixed per-digit dwell and a per-dwell PWM brightness duty.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           display enable; when low the scan is parked at digit 0 and outputs go dark
//   luminance    brightness 0 (1/16 duty) .. 15 (full duty)
//   hexx         nibble i (hexx[4i+3:4i]) is shown on digit i
//   points       decimal point per digit
//   blank        1 = digit always dark
//   blink        1 = digit dark during the blink-off phase
//   segments     {a,b,c,d,e,f,g,dp}, registered, polarity applied
//   digits       one-hot digit select, registered, polarity applied
//   frame_start  one-clock pulse coincident with digit 0 starting its dwell
module seg7_scan_driver #(
  parameter int unsigned NDIGITS        = 4,
  parameter int unsigned PRESCALE_W     = 12,
  parameter int unsigned BLINK_W        = 24,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [3:0]           luminance,
  input  logic [4*NDIGITS-1:0] hexx,
  input  logic [NDIGITS-1:0]   points,
  input  logic [NDIGITS-1:0]   blank,
  input  logic [NDIGITS-1:0]   blink,
  output logic [7:0]           segments,
  output logic [NDIGITS-1:0]   digits,
  output logic                 frame_start
);

  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  localparam logic [7:0]         SEG_IDLE = {8{SEG_ACTIVE_LOW}};
  localparam logic [NDIGITS-1:0] DIG_IDLE = {NDIGITS{DIG_ACTIVE_LOW}};

  // Scan state
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    bc_q, bc_d;

  // Per-frame snapshot of the display inputs
  logic [4*NDIGITS-1:0] hexx_q;
  logic [NDIGITS-1:0]   points_q, blank_q, blink_q;
  logic [3:0]           lum_q;

  // Registered outputs, already in pin polarity
  logic [7:0]         segments_q, segments_d;
  logic [NDIGITS-1:0] digits_q, digits_d;
  logic               frame_start_q, frame_start_d;

  logic frame_tick;
  assign frame_tick = (idx_q == '0) && (pc_q == '0);

  // On the frame-boundary clock the snapshot register is being loaded this very edge, so the
  // output path looks straight at the inputs; otherwise digit 0's first clock would show the
  // previous frame's values.
  logic [4*NDIGITS-1:0] hexx_eff;
  logic [NDIGITS-1:0]   points_eff, blank_eff, blink_eff;
  logic [3:0]           lum_eff;

  always_comb begin
    hexx_eff   = frame_tick ? hexx      : hexx_q;
    points_eff = frame_tick ? points    : points_q;
    blank_eff  = frame_tick ? blank     : blank_q;
    blink_eff  = frame_tick ? blink     : blink_q;
    lum_eff    = frame_tick ? luminance : lum_q;
  end

  // Counters: pc/idx parked at zero while disabled, bc free-running
  always_comb begin
    pc_d  = pc_q;
    idx_d = idx_q;
    bc_d  = bc_q + BLINK_W'(1);
    if (en) begin
      pc_d = pc_q + PRESCALE_W'(1);
      if (pc_q == '1) begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end else begin
      pc_d  = '0;
      idx_d = '0;
    end
  end

  logic [3:0] nibble;
  logic [6:0] dec;
  logic       duty_on;
  logic       lit;

  assign nibble = hexx_eff[{idx_q, 2'b00} +: 4];

  always_comb begin
    case (nibble)
      4'h0:    dec = 7'h7E;
      4'h1:    dec = 7'h30;
      4'h2:    dec = 7'h6D;
      4'h3:    dec = 7'h79;
      4'h4:    dec = 7'h33;
      4'h5:    dec = 7'h5B;
      4'h6:    dec = 7'h5F;
      4'h7:    dec = 7'h70;
      4'h8:    dec = 7'h7F;
      4'h9:    dec = 7'h7B;
      4'hA:    dec = 7'h77;
      4'hB:    dec = 7'h1F;
      4'hC:    dec = 7'h4E;
      4'hD:    dec = 7'h3D;
      4'hE:    dec = 7'h4F;
      default: dec = 7'h47;
    endcase
  end

  // PWM: the top four dwell-counter bits sweep 0..15 once per dwell
  assign duty_on = (pc_q[PRESCALE_W-1 -: 4] <= lum_eff);

  assign lit = en & duty_on & ~blank_eff[idx_q] & ~(blink_eff[idx_q] & bc_q[BLINK_W-1]);

  always_comb begin
    segments_d    = SEG_IDLE;
    digits_d      = DIG_IDLE;
    frame_start_d = en & frame_tick;
    if (lit) begin
      segments_d = {dec, points_eff[idx_q]} ^ SEG_IDLE;
      digits_d   = (NDIGITS'(1) << idx_q) ^ DIG_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      idx_q         <= '0;
      bc_q          <= '0;
      hexx_q        <= '0;
      points_q      <= '0;
      blank_q       <= '0;
      blink_q       <= '0;
      lum_q         <= '0;
      segments_q    <= SEG_IDLE;
      digits_q      <= DIG_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      bc_q          <= bc_d;
      if (frame_tick) begin
        hexx_q   <= hexx;
        points_q <= points;
        blank_q  <= blank;
        blink_q  <= blink;
        lum_q    <= luminance;
      end
      segments_q    <= segments_d;
      digits_q      <= digits_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segments    = segments_q;
  assign digits      = digits_q;
  assign frame_start = frame_start_q;

endmodule
